// File: rtl/method_vec_caller.sv
// Caller-side adapter for a vector-argument ActionValue method: gathers argument
// elements from a stream, fires one EN/RDY call, then streams the result back out.
module method_vec_caller #(
    parameter int N_ELEM  = 3,
    parameter int FIELD_W = 4,
    parameter int N_FIELD = 3,
    localparam int ELEM_W = FIELD_W * N_FIELD,
    localparam int VEC_W  = N_ELEM * ELEM_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              RDY_method,
    output logic              EN_method,
    output logic [VEC_W-1:0]  method_arg,
    input  logic [VEC_W-1:0]  method_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_last,
    output logic [15:0]       call_count
);

    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_CALL    = 2'd1;
    localparam logic [1:0] S_EMIT    = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ELEM_W-1:0] arg_q [N_ELEM];
    logic [VEC_W-1:0]  res_q;
    logic [15:0]       call_count_q;
    logic [ELEM_W-1:0] res_elem [N_ELEM];

    logic idx_last;
    logic in_fire;
    logic call_fire;
    logic out_fire;

    assign idx_last = (idx_q == IDX_W'(N_ELEM - 1));

    // Handshake outputs are gated by RST so nothing is offered or accepted during reset.
    assign in_ready  = !RST && (state_q == S_COLLECT);
    assign EN_method = !RST && (state_q == S_CALL) && RDY_method;
    assign out_valid = !RST && (state_q == S_EMIT);
    assign out_last  = out_valid && idx_last;
    assign out_data  = res_elem[idx_q];

    assign in_fire   = in_ready && in_valid;
    assign call_fire = EN_method;
    assign out_fire  = out_valid && out_ready;

    assign call_count = call_count_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_COLLECT: begin
                if (in_fire) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = S_CALL;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_CALL: begin
                if (call_fire) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_fire) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = S_COLLECT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                idx_d   = '0;
                state_d = S_COLLECT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_COLLECT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Only written when a call completes, so the counter holds otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            res_q        <= '0;
            call_count_q <= '0;
        end else if (call_fire) begin
            res_q        <= method_res;
            call_count_q <= call_count_q + 16'd1;
        end
    end

    // Element 0 lives in the MSBs of both the argument and result vectors.
    generate
        for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_slot
            always_ff @(posedge CLK) begin
                if (RST) begin
                    arg_q[gi] <= '0;
                end else if (in_fire && (idx_q == IDX_W'(gi))) begin
                    arg_q[gi] <= in_data;
                end
            end
            assign method_arg[(N_ELEM-gi)*ELEM_W-1 -: ELEM_W] = arg_q[gi];
            assign res_elem[gi] = res_q[(N_ELEM-gi)*ELEM_W-1 -: ELEM_W];
        end
    endgenerate

endmodule

// File: tb/tb_method_vec_caller.sv
// Directed bench for method_vec_caller: pack, callee stall, unpack, backpressure,
// mid-collect reset and call counter wrap.
module tb_method_vec_caller;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        RDY_method;
    logic        EN_method;
    logic [35:0] method_arg;
    logic [35:0] method_res;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_last;
    logic [15:0] call_count;

    int checks   = 0;
    int failures = 0;

    method_vec_caller dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .RDY_method (RDY_method),
        .EN_method  (EN_method),
        .method_arg (method_arg),
        .method_res (method_res),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .call_count (call_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are checked before the next edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_elem(input logic [11:0] d);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        check("in_ready_collect", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [11:0] d, input logic last);
        out_ready = 1'b1;
        #1;
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_data"}, {52'd0, out_data}, {52'd0, d});
        check({tag, "_last"}, {63'd0, out_last}, {63'd0, last});
        tick();
    endtask

    initial begin
        RST        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        RDY_method = 1'b1;
        method_res = '0;
        out_ready  = 1'b0;
        tick();
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_en", {63'd0, EN_method}, 64'd0);
        tick();
        RST = 1'b0;
        #1;
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);
        check("idle_arg", {28'd0, method_arg}, 64'd0);
        check("idle_count", {48'd0, call_count}, 64'd0);

        // Basic pack and unpack with no stalls.
        send_elem(12'h123);
        send_elem(12'h456);
        send_elem(12'h789);
        method_res = 36'hABCDEF012;
        #1;
        check("pack_arg", {28'd0, method_arg}, 64'h123456789);
        check("call_in_ready", {63'd0, in_ready}, 64'd0);
        check("call_en", {63'd0, EN_method}, 64'd1);
        tick();
        method_res = '0;
        check("emit_en_low", {63'd0, EN_method}, 64'd0);
        check("count_1", {48'd0, call_count}, 64'd1);
        expect_beat("b0", 12'hABC, 1'b0);
        expect_beat("b1", 12'hDEF, 1'b0);
        expect_beat("b2", 12'h012, 1'b1);
        #1;
        check("back_collect", {63'd0, in_ready}, 64'd1);
        check("back_no_valid", {63'd0, out_valid}, 64'd0);

        // Callee stall, in_valid ignored during CALL, then backpressure on beat 1.
        RDY_method = 1'b0;
        send_elem(12'hAAA);
        send_elem(12'hBBB);
        send_elem(12'hCCC);
        in_valid = 1'b1;
        in_data  = 12'hFFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_en", {63'd0, EN_method}, 64'd0);
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("stall_arg", {28'd0, method_arg}, 64'hAAABBBCCC);
            tick();
        end
        in_valid   = 1'b0;
        RDY_method = 1'b1;
        method_res = 36'hABCDEF012;
        #1;
        check("stall_en_rise", {63'd0, EN_method}, 64'd1);
        tick();
        method_res = 36'h555555555;
        check("count_2", {48'd0, call_count}, 64'd2);
        expect_beat("s0", 12'hABC, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_data", {52'd0, out_data}, 64'hDEF);
            tick();
        end
        expect_beat("s1", 12'hDEF, 1'b0);
        expect_beat("s2", 12'h012, 1'b1);

        // Reset after two accepts discards the partial argument.
        send_elem(12'h111);
        send_elem(12'h222);
        RST      = 1'b1;
        in_valid = 1'b1;
        in_data  = 12'h333;
        #1;
        check("rst_mid_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        RST      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_mid_arg", {28'd0, method_arg}, 64'd0);
        check("rst_mid_count", {48'd0, call_count}, 64'd0);
        send_elem(12'h321);
        send_elem(12'h654);
        send_elem(12'h987);
        method_res = 36'h0000000FF;
        #1;
        check("fresh_arg", {28'd0, method_arg}, 64'h321654987);
        check("fresh_en", {63'd0, EN_method}, 64'd1);
        tick();
        expect_beat("f0", 12'h000, 1'b0);
        expect_beat("f1", 12'h000, 1'b0);
        expect_beat("f2", 12'h0FF, 1'b1);
        #1;
        check("fresh_count", {48'd0, call_count}, 64'd1);

        // Counter wrap from a forced start value of 0xFFFF.
        force dut.call_count_q = 16'hFFFF;
        tick();
        release dut.call_count_q;
        #1;
        check("wrap_pre", {48'd0, call_count}, 64'hFFFF);
        send_elem(12'h001);
        send_elem(12'h002);
        send_elem(12'h003);
        method_res = 36'h00A00B00C;
        tick();
        check("wrap_count", {48'd0, call_count}, 64'd0);
        expect_beat("w0", 12'h00A, 1'b0);
        expect_beat("w1", 12'h00B, 1'b0);
        expect_beat("w2", 12'h00C, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000ns");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
